mem_port_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the CPU instruction-fetch requester and the data (load/store) requester.
- Sits between the pipeline's inst/data request interfaces and the downstream bus bridge.
- Accepts one request at a time and sequences it through the address and data phases.
- Returns the response to the requester that owns the transaction.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one SRAM-like memory port between instruction-fetch and load/store requesters.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention; otherwise data has fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [1:0]          mem_size,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_RESP
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    state_t              r_state;
    owner_t              r_owner;
    logic                r_wr;
    logic [1:0]          r_size;
    logic [STRB_W-1:0]   r_wstrb;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_grantData;
    logic                w_grantInst;
    logic                w_accept;
    logic                w_inAddr;
    logic                w_respDone;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t              r_lastOwner;

    // On contention the requester that did not win last time gets the port.
    assign w_grantData = data_req && (!inst_req || (r_lastOwner == OWN_INST));
`else
    assign w_grantData = data_req;
`endif
    assign w_grantInst = inst_req && !w_grantData;

    // Acceptance only happens from IDLE, so the cycle that returns data_ok never accepts.
    assign w_accept   = (r_state == S_IDLE) && !reset;
    assign w_inAddr   = (r_state == S_ADDR);
    assign w_respDone = (r_state == S_RESP) && mem_data_ok && !reset;

    assign inst_addr_ok = w_accept && w_grantInst;
    assign data_addr_ok = w_accept && w_grantData;

    assign inst_data_ok = w_respDone && (r_owner == OWN_INST);
    assign data_data_ok = w_respDone && (r_owner == OWN_DATA);
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;

    assign mem_req   = w_inAddr;
    assign mem_wr    = w_inAddr ? r_wr    : 1'b0;
    assign mem_size  = w_inAddr ? r_size  : 2'd0;
    assign mem_wstrb = w_inAddr ? r_wstrb : '0;
    assign mem_addr  = w_inAddr ? r_addr  : '0;
    assign mem_wdata = w_inAddr ? r_wdata : '0;

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_owner <= OWN_INST;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_wstrb <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grantData || w_grantInst) begin
                        // Instruction fetches are always word reads with no byte enables.
                        r_owner <= w_grantData ? OWN_DATA : OWN_INST;
                        r_wr    <= w_grantData && data_wr;
                        r_size  <= w_grantData ? data_size : 2'd2;
                        r_wstrb <= (w_grantData && data_wr) ? data_wstrb : '0;
                        r_addr  <= w_grantData ? data_addr : inst_addr;
                        r_wdata <= w_grantData ? data_wdata : '0;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (mem_addr_ok) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (mem_data_ok) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lastOwner <= OWN_INST;
        end else if (w_accept && (w_grantData || w_grantInst)) begin
            r_lastOwner <= w_grantData ? OWN_DATA : OWN_INST;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter: one record per clock cycle of inputs and expected outputs.
// Contention expectations follow ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy;

    int nCompared = 0;
    int nMismatched = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iReq;
        logic [31:0] iAddr;
        logic        dReq;
        logic        dWr;
        logic [1:0]  dSize;
        logic [3:0]  dStrb;
        logic [31:0] dAddr;
        logic [31:0] dWdata;
        logic        mAok;
        logic        mDok;
        logic [31:0] mRdata;
        logic        eIAok;
        logic        eIDok;
        logic [31:0] eIRdata;
        logic        eDAok;
        logic        eDDok;
        logic [31:0] eDRdata;
        logic        eMReq;
        logic        eMWr;
        logic [1:0]  eMSize;
        logic [3:0]  eMStrb;
        logic [31:0] eMAddr;
        logic [31:0] eMWdata;
        logic        eBusy;
    } vec_t;

    vec_t vecs[$];
    vec_t v;

    task automatic newVec();
        v = '{default: '0};
    endtask

    task automatic pushVec();
        vecs.push_back(v);
    endtask

    // Expected downstream fields while the arbiter sits in ADDR.
    task automatic expMem(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                          input logic [3:0] strb, input logic [31:0] wdata);
        v.eMReq  = 1'b1;
        v.eMAddr = addr;
        v.eMWr   = wr;
        v.eMSize = size;
        v.eMStrb = strb;
        v.eMWdata = wdata;
        v.eBusy  = 1'b1;
    endtask

    task automatic contReqs();
        v.iReq  = 1'b1;
        v.iAddr = 32'h1C00_0100;
        v.dReq  = 1'b1;
        v.dAddr = 32'h0000_4000;
        v.dSize = 2'd2;
    endtask

    // One contended transaction: accept, address phase, response phase.
    task automatic addContention(input logic dataWins, input logic [31:0] rd);
        newVec(); contReqs();
        v.eIAok = !dataWins;
        v.eDAok = dataWins;
        pushVec();
        newVec(); contReqs();
        v.mAok = 1'b1;
        expMem(dataWins ? 32'h0000_4000 : 32'h1C00_0100, 1'b0, 2'd2, 4'h0, 32'h0);
        pushVec();
        newVec(); contReqs();
        v.mDok = 1'b1; v.mRdata = rd; v.eBusy = 1'b1;
        if (dataWins) begin
            v.eDDok = 1'b1; v.eDRdata = rd;
        end else begin
            v.eIDok = 1'b1; v.eIRdata = rd;
        end
        pushVec();
    endtask

    task automatic applyStimulus(input vec_t x);
        @(posedge clk);
        #1;
        reset       = x.rst;
        inst_req    = x.iReq;
        inst_addr   = x.iAddr;
        data_req    = x.dReq;
        data_wr     = x.dWr;
        data_size   = x.dSize;
        data_wstrb  = x.dStrb;
        data_addr   = x.dAddr;
        data_wdata  = x.dWdata;
        mem_addr_ok = x.mAok;
        mem_data_ok = x.mDok;
        mem_rdata   = x.mRdata;
    endtask

    task automatic cmp(input int idx, input string what, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL vec%0d %s: got %h, expected %h", idx, what, act, exp);
        end
    endtask

    task automatic checkOutput(input int idx, input vec_t x);
        @(negedge clk);
        cmp(idx, "inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, x.eIAok});
        cmp(idx, "inst_data_ok", {31'b0, inst_data_ok}, {31'b0, x.eIDok});
        cmp(idx, "inst_rdata",   inst_rdata,            x.eIRdata);
        cmp(idx, "data_addr_ok", {31'b0, data_addr_ok}, {31'b0, x.eDAok});
        cmp(idx, "data_data_ok", {31'b0, data_data_ok}, {31'b0, x.eDDok});
        cmp(idx, "data_rdata",   data_rdata,            x.eDRdata);
        cmp(idx, "mem_req",      {31'b0, mem_req},      {31'b0, x.eMReq});
        cmp(idx, "mem_wr",       {31'b0, mem_wr},       {31'b0, x.eMWr});
        cmp(idx, "mem_size",     {30'b0, mem_size},     {30'b0, x.eMSize});
        cmp(idx, "mem_wstrb",    {28'b0, mem_wstrb},    {28'b0, x.eMStrb});
        cmp(idx, "mem_addr",     mem_addr,              x.eMAddr);
        cmp(idx, "mem_wdata",    mem_wdata,             x.eMWdata);
        cmp(idx, "busy",         {31'b0, busy},         {31'b0, x.eBusy});
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_wstrb = '0;
        data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;

        // Reset state.
        newVec(); v.rst = 1'b1; pushVec();

        // Lone instruction read, best-case latency.
        newVec(); v.iReq = 1'b1; v.iAddr = 32'h1C00_0000; v.eIAok = 1'b1; pushVec();
        newVec(); v.mAok = 1'b1; expMem(32'h1C00_0000, 1'b0, 2'd2, 4'h0, 32'h0); pushVec();
        newVec(); v.mDok = 1'b1; v.mRdata = 32'h0280_0C0C;
        v.eIDok = 1'b1; v.eIRdata = 32'h0280_0C0C; v.eBusy = 1'b1; pushVec();

        // Stray response in IDLE with no requests.
        newVec(); v.mDok = 1'b1; v.mRdata = 32'h1234_5678; pushVec();

        // Word store; one cycle of address backpressure and one of response wait.
        newVec(); v.dReq = 1'b1; v.dWr = 1'b1; v.dSize = 2'd2; v.dStrb = 4'hF;
        v.dAddr = 32'h0000_1000; v.dWdata = 32'hDEAD_BEEF; v.eDAok = 1'b1; pushVec();
        newVec(); expMem(32'h0000_1000, 1'b1, 2'd2, 4'hF, 32'hDEAD_BEEF); pushVec();
        newVec(); v.mAok = 1'b1; expMem(32'h0000_1000, 1'b1, 2'd2, 4'hF, 32'hDEAD_BEEF); pushVec();
        newVec(); v.eBusy = 1'b1; pushVec();
        newVec(); v.mDok = 1'b1; v.mRdata = 32'hAAAA_5555;
        v.eDDok = 1'b1; v.eDRdata = 32'hAAAA_5555; v.eBusy = 1'b1; pushVec();

        // Byte load: byte enables must be suppressed because data_wr=0.
        newVec(); v.dReq = 1'b1; v.dSize = 2'd0; v.dStrb = 4'hF;
        v.dAddr = 32'h0000_2003; v.dWdata = 32'h1111_1111; v.eDAok = 1'b1; pushVec();
        newVec(); v.mAok = 1'b1; expMem(32'h0000_2003, 1'b0, 2'd0, 4'h0, 32'h1111_1111); pushVec();
        newVec(); v.mDok = 1'b1; v.mRdata = 32'h0000_00C3;
        v.eDDok = 1'b1; v.eDRdata = 32'h0000_00C3; v.eBusy = 1'b1; pushVec();

        // Backpressure: data owns the port, inst waits through 5 stalled cycles and the response.
        newVec(); v.dReq = 1'b1; v.dSize = 2'd2; v.dAddr = 32'h0000_3000; v.eDAok = 1'b1; pushVec();
        for (int i = 0; i < 6; i++) begin
            newVec(); v.iReq = 1'b1; v.iAddr = 32'h1C00_0040;
            v.mAok = (i == 5);
            expMem(32'h0000_3000, 1'b0, 2'd2, 4'h0, 32'h0);
            pushVec();
        end
        newVec(); v.iReq = 1'b1; v.iAddr = 32'h1C00_0040; v.mDok = 1'b1; v.mRdata = 32'hCAFE_F00D;
        v.eDDok = 1'b1; v.eDRdata = 32'hCAFE_F00D; v.eBusy = 1'b1; pushVec();
        newVec(); v.iReq = 1'b1; v.iAddr = 32'h1C00_0040; v.eIAok = 1'b1; pushVec();
        newVec(); v.mAok = 1'b1; expMem(32'h1C00_0040, 1'b0, 2'd2, 4'h0, 32'h0); pushVec();
        newVec(); v.mDok = 1'b1; v.mRdata = 32'h0000_0013;
        v.eIDok = 1'b1; v.eIRdata = 32'h0000_0013; v.eBusy = 1'b1; pushVec();

        // Reset while waiting in RESP; the late response must be ignored.
        newVec(); v.iReq = 1'b1; v.iAddr = 32'h1C00_0080; v.eIAok = 1'b1; pushVec();
        newVec(); v.mAok = 1'b1; expMem(32'h1C00_0080, 1'b0, 2'd2, 4'h0, 32'h0); pushVec();
        newVec(); v.eBusy = 1'b1; pushVec();
        newVec(); v.rst = 1'b1; v.eBusy = 1'b1; pushVec();
        newVec(); v.mDok = 1'b1; v.mRdata = 32'hDEAD_0001; pushVec();
        newVec(); pushVec();

        // Contention with both requests held for three transactions.
`ifdef ARB_ROUND_ROBIN_EN
        addContention(1'b1, 32'h0000_0A01);
        addContention(1'b0, 32'h0000_0A02);
        addContention(1'b1, 32'h0000_0A03);
`else
        addContention(1'b1, 32'h0000_0A01);
        addContention(1'b1, 32'h0000_0A02);
        addContention(1'b1, 32'h0000_0A03);
`endif
        newVec(); pushVec();

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
